// File: rtl/spi_frame_decoder_if.sv
// SPI pin bundle plus decoded frame-buffer write port for spi_frame_decoder.
// The write port has no ready: when we=1, waddr/wdata are valid for that single cycle and must be taken then.
interface spi_frame_decoder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              sck;
    logic              cs;
    logic              sdi;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic              frame_err;
    logic              busy;
    logic [1:0]        state_dbg;

    modport slave (
        input  sck, cs, sdi,
        output we, waddr, wdata, done, frame_err, busy, state_dbg
    );

    modport master (
        output sck, cs, sdi,
        input  we, waddr, wdata, done, frame_err, busy, state_dbg
    );
endinterface

// File: rtl/spi_frame_decoder.sv
// SPI mode-0 slave front-end: synchronises the pins, decodes address + burst data
// words into one-cycle frame-buffer writes, and flags clean or truncated frame ends.
module spi_frame_decoder #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int CS_ACTIVE_HIGH = 1
) (
    input logic                 clk,
    input logic                 reset,
    spi_frame_decoder_if.slave  bus
);
    localparam int   MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int   CNT_W  = $clog2(MAX_W) + 1;
    localparam logic CS_ACT = (CS_ACTIVE_HIGH != 0);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, sdi_s, sel, sel_d;
    logic                   sck_rise, sel_rise, sel_fall;

    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [MAX_W-1:0]  shreg, shreg_n;
    logic [ADDR_W-1:0] addr_reg;
    logic              wrote_any, end_ok, end_ok_n;
    logic              shift_en, addr_done, word_done;

    // cs stages reset to the selected level so a frame already in flight at
    // reset release never looks like a fresh select edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            cs_sync  <= {SYNC_STAGES{CS_ACT}};
            sck_d    <= 1'b0;
            cs_d     <= CS_ACT;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            cs_d     <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign sel      = ~(cs_sync[SYNC_STAGES-1] ^ CS_ACT);
    assign sel_d    = ~(cs_d ^ CS_ACT);
    assign sck_rise = sck_s & ~sck_d;
    assign sel_rise = sel & ~sel_d;
    assign sel_fall = ~sel & sel_d;

    assign cnt_inc = cnt + 1'b1;
    assign shreg_n = {shreg[MAX_W-2:0], sdi_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        shift_en  = 1'b0;
        addr_done = 1'b0;
        word_done = 1'b0;
        case (state)
            S_IDLE: if (sel_rise) state_n = S_ADDR;
            S_ADDR: begin
                shift_en = sck_rise;
                if (sck_rise && (cnt_inc == CNT_W'(ADDR_W))) begin
                    addr_done = 1'b1;
                    state_n   = S_DATA;
                end
                if (sel_fall) state_n = S_END;
            end
            S_DATA: begin
                shift_en = sck_rise;
                if (sck_rise && (cnt_inc == CNT_W'(DATA_W))) word_done = 1'b1;
                if (sel_fall) state_n = S_END;
            end
            S_END:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // A final bit arriving with the deselect is counted before the end is judged.
    assign end_ok_n = (state == S_DATA) &&
                      (word_done || (!sck_rise && (cnt == '0) && wrote_any));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            shreg         <= '0;
            addr_reg      <= '0;
            wrote_any     <= 1'b0;
            end_ok        <= 1'b0;
            bus.we        <= 1'b0;
            bus.waddr     <= '0;
            bus.wdata     <= '0;
            bus.done      <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.we        <= word_done;
            bus.done      <= (state == S_END) && end_ok;
            bus.frame_err <= (state == S_END) && !end_ok;
            if (state == S_IDLE) begin
                cnt       <= '0;
                shreg     <= '0;
                wrote_any <= 1'b0;
            end else if (shift_en) begin
                shreg <= shreg_n;
                cnt   <= (addr_done || word_done) ? '0 : cnt_inc;
            end
            if (addr_done) addr_reg <= shreg_n[ADDR_W-1:0];
            if (word_done) begin
                bus.waddr <= addr_reg;
                bus.wdata <= shreg_n[DATA_W-1:0];
                addr_reg  <= addr_reg + ADDR_W'(1);
                wrote_any <= 1'b1;
            end
            if (sel_fall && ((state == S_ADDR) || (state == S_DATA))) end_ok <= end_ok_n;
        end
    end

    assign bus.busy      = (state == S_ADDR) || (state == S_DATA);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_spi_frame_decoder.sv
// Bench for spi_frame_decoder: both cs polarities driven from one pin set,
// table vectors, reset mid-word, and random frames against a frame-level model.
module tb_spi_frame_decoder;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 8;
    localparam int SCK_HALF = 3;
    localparam int WORD_GAP = DATA_W * 2 * SCK_HALF;
    localparam int WR_W     = ADDR_W + DATA_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    spi_frame_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_h ();
    spi_frame_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_l ();

    assign bus_l.sck = bus_h.sck;
    assign bus_l.sdi = bus_h.sdi;
    assign bus_l.cs  = ~bus_h.cs;

    spi_frame_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2), .CS_ACTIVE_HIGH(1))
        dut_h (.clk(clk), .reset(reset), .bus(bus_h.slave));
    spi_frame_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2), .CS_ACTIVE_HIGH(0))
        dut_l (.clk(clk), .reset(reset), .bus(bus_l.slave));

    int tests = 0;
    int fails = 0;

    // Output capture
    logic [WR_W-1:0] cap_h[$], cap_l[$];
    int              cyc_h[$], cyc_l[$];
    int              done_h, done_l, err_h, err_l, viol;
    logic            we_h_d = 1'b0, we_l_d = 1'b0;

    always @(negedge clk) begin
        if (bus_h.we) begin cap_h.push_back({bus_h.waddr, bus_h.wdata}); cyc_h.push_back(cycle); end
        if (bus_l.we) begin cap_l.push_back({bus_l.waddr, bus_l.wdata}); cyc_l.push_back(cycle); end
        if (bus_h.done) done_h++;
        if (bus_l.done) done_l++;
        if (bus_h.frame_err) err_h++;
        if (bus_l.frame_err) err_l++;
        if (bus_h.we && (bus_h.done || bus_h.frame_err)) viol++;
        if (bus_l.we && (bus_l.done || bus_l.frame_err)) viol++;
        if (bus_h.done && bus_h.frame_err) viol++;
        if (bus_l.done && bus_l.frame_err) viol++;
        if (bus_h.we && we_h_d) viol++;
        if (bus_l.we && we_l_d) viol++;
        we_h_d = bus_h.we;
        we_l_d = bus_l.we;
    end

    // Reference model state
    logic            tx_bits[$];
    logic [WR_W-1:0] exp_q[$];
    int              exp_done, exp_err;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [DATA_W-1:0] hold_data = '0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                nw;
        logic [31:0]       dw;
        int                nbits;
        bit                coinc;
        int                exp_we;
        int                exp_done;
        int                exp_err;
        logic [ADDR_W-1:0] exp_waddr;
        logic [DATA_W-1:0] exp_wdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_h.delete(); cap_l.delete(); cyc_h.delete(); cyc_l.delete();
        done_h = 0; done_l = 0; err_h = 0; err_l = 0;
    endtask

    task automatic build_frame(input logic [ADDR_W-1:0] a, input int nw, input logic [31:0] dw);
        logic [7:0] word;
        tx_bits.delete();
        for (int i = ADDR_W - 1; i >= 0; i--) tx_bits.push_back(a[i]);
        for (int w = 0; w < nw; w++) begin
            word = dw[8*(3-w) +: 8];
            for (int b = 7; b >= 0; b--) tx_bits.push_back(word[b]);
        end
    endtask

    // Frame-level rules: address first, then whole words; anything else is truncated.
    task automatic model_frame(input int nbits);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int nw;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        if (nbits < ADDR_W) begin
            exp_err = 1;
            return;
        end
        a = '0;
        for (int i = 0; i < ADDR_W; i++) a = {a[ADDR_W-2:0], tx_bits[i]};
        nw = (nbits - ADDR_W) / DATA_W;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            for (int b = 0; b < DATA_W; b++) d = {d[DATA_W-2:0], tx_bits[ADDR_W + DATA_W*w + b]};
            exp_q.push_back({a + ADDR_W'(w), d});
            hold_addr = a + ADDR_W'(w);
            hold_data = d;
        end
        if (nw > 0 && ((nbits - ADDR_W) % DATA_W) == 0) exp_done = 1;
        else exp_err = 1;
    endtask

    task automatic send_bits(input int from, input int upto, input bit coinc_last);
        for (int i = from; i < upto; i++) begin
            bus_h.sdi = tx_bits[i];
            wait_clks(SCK_HALF);
            bus_h.sck = 1'b1;
            if (coinc_last && i == upto - 1) bus_h.cs = 1'b0;
            wait_clks(SCK_HALF);
            bus_h.sck = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbits, input bit coinc);
        bus_h.cs = 1'b1;
        wait_clks(4);
        send_bits(0, nbits, coinc);
        if (!coinc) begin
            wait_clks(SCK_HALF);
            bus_h.cs = 1'b0;
        end
        wait_clks(12);
    endtask

    task automatic check_dut(input string tag, input logic [WR_W-1:0] got[$], input int cyc[$],
                             input int nd, input int ne,
                             input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        chk({tag, "_we_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_write"}, got[i], exp_q[i]);
        for (int i = 1; i < cyc.size(); i++)
            chk({tag, "_we_gap"}, cyc[i] - cyc[i-1], WORD_GAP);
        chk({tag, "_done"}, nd, exp_done);
        chk({tag, "_frame_err"}, ne, exp_err);
        chk({tag, "_waddr_hold"}, wa, hold_addr);
        chk({tag, "_wdata_hold"}, wd, hold_data);
    endtask

    task automatic run_frame(input int nbits, input bit coinc);
        model_frame(nbits);
        send_frame(nbits, coinc);
        check_dut("hi", cap_h, cyc_h, done_h, err_h, bus_h.waddr, bus_h.wdata);
        check_dut("lo", cap_l, cyc_l, done_l, err_l, bus_l.waddr, bus_l.wdata);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_hi_we"}, bus_h.we, 0);
        chk({tag, "_hi_done"}, bus_h.done, 0);
        chk({tag, "_hi_err"}, bus_h.frame_err, 0);
        chk({tag, "_hi_busy"}, bus_h.busy, 0);
        chk({tag, "_hi_waddr"}, bus_h.waddr, 0);
        chk({tag, "_hi_wdata"}, bus_h.wdata, 0);
        chk({tag, "_lo_we"}, bus_l.we, 0);
        chk({tag, "_lo_busy"}, bus_l.busy, 0);
        chk({tag, "_lo_waddr"}, bus_l.waddr, 0);
        chk({tag, "_lo_wdata"}, bus_l.wdata, 0);
    endtask

    initial begin
        int nw, full, nbits;
        bit coinc;

        vecs[0] = '{12'h123, 1, 32'hA500_0000, 20, 1'b0, 1, 1, 0, 12'h123, 8'hA5};
        vecs[1] = '{12'hFFE, 3, 32'h1122_3300, 36, 1'b0, 3, 1, 0, 12'h000, 8'h33};
        vecs[2] = '{12'h040, 1, 32'hFF00_0000, 17, 1'b0, 0, 0, 1, 12'h000, 8'h33};
        vecs[3] = '{12'h041, 1, 32'h7E00_0000, 20, 1'b0, 1, 1, 0, 12'h041, 8'h7E};
        vecs[4] = '{12'h5A5, 0, 32'h0,          7, 1'b0, 0, 0, 1, 12'h041, 8'h7E};
        vecs[5] = '{12'h300, 0, 32'h0,         12, 1'b0, 0, 0, 1, 12'h041, 8'h7E};
        vecs[6] = '{12'h0AB, 1, 32'hC300_0000, 20, 1'b1, 1, 1, 0, 12'h0AB, 8'hC3};

        bus_h.sck = 1'b0;
        bus_h.sdi = 1'b0;
        bus_h.cs  = 1'b0;
        viol = 0;
        clear_caps();

        // Clock/reset
        wait_clks(3);
        check_outputs_zero("reset");
        reset = 1'b1;
        wait_clks(6);
        clear_caps();

        // Directed table
        foreach (vecs[k]) begin
            build_frame(vecs[k].addr, vecs[k].nw, vecs[k].dw);
            run_frame(vecs[k].nbits, vecs[k].coinc);
            chk("tbl_we_count", cap_h.size(), vecs[k].exp_we);
            chk("tbl_done", done_h, vecs[k].exp_done);
            chk("tbl_err", err_h, vecs[k].exp_err);
            chk("tbl_waddr", bus_h.waddr, vecs[k].exp_waddr);
            chk("tbl_wdata", bus_h.wdata, vecs[k].exp_wdata);
            chk("tbl_lo_waddr", bus_l.waddr, vecs[k].exp_waddr);
            clear_caps();
        end

        // Reset in the middle of a data word, then finish that frame's pin activity
        build_frame(12'h155, 2, 32'h9C3C_0000);
        bus_h.cs = 1'b1;
        wait_clks(4);
        send_bits(0, ADDR_W + 4, 1'b0);
        wait_clks(1);
        chk("mid_frame_busy_hi", bus_h.busy, 1);
        chk("mid_frame_busy_lo", bus_l.busy, 1);
        reset = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        wait_clks(2);
        reset = 1'b1;
        hold_addr = '0;
        hold_data = '0;
        send_bits(ADDR_W + 4, ADDR_W + 2*DATA_W, 1'b0);
        wait_clks(SCK_HALF);
        bus_h.cs = 1'b0;
        wait_clks(12);
        chk("post_reset_we_hi", cap_h.size(), 0);
        chk("post_reset_we_lo", cap_l.size(), 0);
        chk("post_reset_end_hi", done_h + err_h, 0);
        chk("post_reset_end_lo", done_l + err_l, 0);
        clear_caps();
        build_frame(12'h200, 1, 32'h5A00_0000);
        run_frame(ADDR_W + DATA_W, 1'b0);
        chk("fresh_frame_waddr", bus_h.waddr, 12'h200);
        chk("fresh_frame_wdata", bus_h.wdata, 8'h5A);
        clear_caps();

        // Random frames against the model
        for (int r = 0; r < 24; r++) begin
            nw   = $urandom_range(0, 3);
            full = ADDR_W + DATA_W * nw;
            build_frame(12'($urandom_range(0, 4095)), nw, $urandom);
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, full - 1) : full;
            coinc = 1'($urandom_range(0, 1));
            run_frame(nbits, coinc);
            clear_caps();
        end

        chk("protocol_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
